// File: rtl/irq_ctl_pkg.sv
// rtl/irq_ctl_pkg.sv - shared constants and helpers for the irq_ctl block
//
// Purpose: register offsets of the 4-byte window, the "no request" vector
// value, and the helper that builds the VECTOR read value.
// Ports: none (package).

package irq_ctl_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_VEC  = 2'd3;

  localparam logic [7:0] VEC_NONE = 8'h80;

  // Bit 7 flags "nothing requesting"; the encoder index sits in [2:0].
  function automatic logic [7:0] vec_value(input logic any, input logic [2:0] idx);
    return any ? {5'b0, idx} : VEC_NONE;
  endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// rtl/irq_ctl_if.sv - CPU register bus between the 65C02 core and irq_ctl
//
// Purpose: groups the core-side address/data/strobe signals and the
// registered read-data return path.
// Signals: AD (address), DI (write data), WE (write enable), RDY (cycle
// enable), DO (registered read data), hit (DO valid this cycle).
// Modports: master = CPU side, slave = controller side.

interface irq_ctl_if;

  logic [15:0] AD;
  logic [7:0]  DI;
  logic        WE;
  logic        RDY;
  logic [7:0]  DO;
  logic        hit;

  modport master (
    output AD, DI, WE, RDY,
    input  DO, hit
  );

  modport slave (
    input  AD, DI, WE, RDY,
    output DO, hit
  );

endinterface

// File: rtl/irq_ctl_prio_enc8.sv
// rtl/irq_ctl_prio_enc8.sv - 8-to-3 lowest-index-first priority encoder
//
// Purpose: picks the lowest set bit of the request vector.
// Ports: i_req (8 request bits), o_idx (index of lowest set bit, 0 when
// none), o_any (at least one bit set).

module prio_enc8 (
  input  logic [7:0] i_req,
  output logic [2:0] o_idx,
  output logic       o_any
);

  // Scan from the top down so the last (lowest) hit overrides.
  always_comb begin
    o_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_req[i]) o_idx = 3'(i);
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/irq_ctl.sv
// rtl/irq_ctl.sv - 8-source interrupt controller with NMI latch for a 65C02
//
// Purpose: latches and masks eight level/rising-edge interrupt sources,
// presents a priority vector register, drives IRQ, and holds NMI until the
// CPU fetches the NMI vector. Decodes a 4-byte register window at BASE.
// Ports:
//   clk      - CPU clock, rising edge
//   RST      - synchronous active-high reset
//   bus      - CPU register bus (irq_ctl_if.slave): AD, DI, WE, RDY in;
//              DO, hit out (registered, valid the cycle after AD)
//   src      - interrupt sources, active-high
//   nmi_src  - NMI source, rising-edge sensitive
//   IRQ      - registered active-high interrupt request to the core
//   NMI      - registered active-high NMI, held until acknowledged

module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter logic [15:0] BASE    = 16'hFE00,
  parameter logic [15:0] NMI_VEC = 16'hFFFA
) (
  input  logic       clk,
  input  logic       RST,
  irq_ctl_if.slave   bus,
  input  logic [7:0] src,
  input  logic       nmi_src,
  output logic       IRQ,
  output logic       NMI
);

  logic [7:0] r_src_q;
  logic [7:0] r_mask;
  logic [7:0] r_edge;
  logic [7:0] r_epend;
  logic       r_nmi_q;
  logic       r_nmi_qq;
  logic       r_nmi;
  logic       r_irq;
  logic [7:0] r_do;
  logic       r_hit;

  logic       w_acc;
  logic       w_wr;
  logic       w_rd;
  logic [1:0] w_off;
  logic [7:0] w_active;
  logic [7:0] w_req;
  logic [2:0] w_idx;
  logic       w_any;
  logic       w_ack;
  logic [7:0] w_clr;
  logic [7:0] w_set;
  logic [7:0] w_epend_nxt;
  logic       w_nmi_rise;
  logic       w_nmi_ack;
  logic [7:0] w_rdata;

  // RDY gates every side effect: a stalled cycle neither writes nor acks.
  assign w_acc = bus.RDY && (bus.AD[15:2] == BASE[15:2]);
  assign w_off = bus.AD[1:0];
  assign w_wr  = w_acc && bus.WE;
  assign w_rd  = w_acc && !bus.WE;

  assign w_active = (r_edge & r_epend) | (~r_edge & r_src_q);
  assign w_req    = w_active & r_mask;

  prio_enc8 u_prio (
    .i_req (w_req),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Only edge latches are cleared by an ack; level sources ignore it
  // because active[] for them comes from src_q, not epend.
  assign w_ack = w_rd && (w_off == REG_VEC) && w_any;

  always_comb begin
    w_clr = 8'h00;
    if (w_wr && (w_off == REG_PEND)) w_clr = w_clr | bus.DI;
    if (w_wr && (w_off == REG_EDGE)) w_clr = w_clr | ~bus.DI;
    if (w_ack)                       w_clr = w_clr | (8'h01 << w_idx);
  end

  // A new edge in the same cycle as a clear wins, so no event is lost.
  assign w_set       = src & ~r_src_q & r_edge;
  assign w_epend_nxt = (r_epend & ~w_clr) | w_set;

  // Two-stage NMI sampling gives NMI the same two-cycle latency as IRQ.
  // Both stages reset to 1 so a source held high through reset is not
  // mistaken for an edge.
  assign w_nmi_rise = r_nmi_q && !r_nmi_qq;
  assign w_nmi_ack  = bus.RDY && !bus.WE && (bus.AD == NMI_VEC);

  // Read data reflects state before this cycle's side effects, so a
  // VECTOR read returns the index it is clearing.
  always_comb begin
    w_rdata = 8'h00;
    unique case (w_off)
      REG_PEND: w_rdata = w_active;
      REG_MASK: w_rdata = r_mask;
      REG_EDGE: w_rdata = r_edge;
      REG_VEC:  w_rdata = vec_value(w_any, w_idx);
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_src_q  <= 8'h00;
      r_mask   <= 8'h00;
      r_edge   <= 8'h00;
      r_epend  <= 8'h00;
      r_nmi_q  <= 1'b1;
      r_nmi_qq <= 1'b1;
      r_nmi    <= 1'b0;
      r_irq    <= 1'b0;
      r_do     <= 8'h00;
      r_hit    <= 1'b0;
    end else begin
      r_src_q  <= src;
      r_nmi_q  <= nmi_src;
      r_nmi_qq <= r_nmi_q;
      r_epend  <= w_epend_nxt;
      if (w_wr && (w_off == REG_MASK)) r_mask <= bus.DI;
      if (w_wr && (w_off == REG_EDGE)) r_edge <= bus.DI;
      r_irq <= w_any;
      if (w_nmi_rise)     r_nmi <= 1'b1;
      else if (w_nmi_ack) r_nmi <= 1'b0;
      r_hit <= w_rd;
      if (w_rd) r_do <= w_rdata;
    end
  end

  assign bus.DO  = r_do;
  assign bus.hit = r_hit;
  assign IRQ     = r_irq;
  assign NMI     = r_nmi;

endmodule

// File: tb/tb_irq_ctl.sv
// tb/tb_irq_ctl.sv - self-checking bench for irq_ctl

module tb_irq_ctl;

  localparam logic [15:0] BASE = 16'hFE00;
  localparam logic [15:0] NMIV = 16'hFFFA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       nmi_src;
  logic       irq;
  logic       nmi;

  irq_ctl_if bus ();

  irq_ctl #(.BASE(BASE), .NMI_VEC(NMIV)) dut (
    .clk     (clk),
    .RST     (rst),
    .bus     (bus),
    .src     (src),
    .nmi_src (nmi_src),
    .IRQ     (irq),
    .NMI     (nmi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_mask, m_edge, m_epend, m_srcq, m_do;
  logic       m_hit, m_irq, m_nmi;
  logic       m_nmi_prev1, m_nmi_prev2;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the register rules for one clock using the
  // inputs presented during that cycle.
  task automatic model_step();
    logic [7:0] act, req, nxt;
    int         idx;
    logic       acc;
    logic [1:0] off;
    if (rst) begin
      m_mask = 0; m_edge = 0; m_epend = 0; m_srcq = 0; m_do = 0;
      m_hit = 0; m_irq = 0; m_nmi = 0;
      m_nmi_prev1 = 1; m_nmi_prev2 = 1;
      return;
    end
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      act[i] = m_edge[i] ? m_epend[i] : m_srcq[i];
      req[i] = act[i] & m_mask[i];
      if (req[i] && idx < 0) idx = i;
    end
    acc = bus.RDY && ((bus.AD >> 2) == (BASE >> 2));
    off = bus.AD[1:0];
    m_hit = acc && !bus.WE;
    if (m_hit) begin
      case (off)
        2'd0: m_do = act;
        2'd1: m_do = m_mask;
        2'd2: m_do = m_edge;
        default: m_do = (idx < 0) ? 8'h80 : 8'(idx);
      endcase
    end
    nxt = m_epend;
    for (int i = 0; i < 8; i++) begin
      if (acc && bus.WE && off == 2'd0 && bus.DI[i]) nxt[i] = 0;
      if (acc && bus.WE && off == 2'd2 && !bus.DI[i]) nxt[i] = 0;
      if (acc && !bus.WE && off == 2'd3 && idx == i) nxt[i] = 0;
      if (src[i] && !m_srcq[i] && m_edge[i]) nxt[i] = 1;
    end
    if (acc && bus.WE && off == 2'd1) m_mask = bus.DI;
    if (acc && bus.WE && off == 2'd2) m_edge = bus.DI;
    m_epend = nxt;
    m_irq = (idx >= 0);
    // NMI rises when nmi_src was seen high after being low the cycle before.
    if (m_nmi_prev1 && !m_nmi_prev2) m_nmi = 1;
    else if (bus.RDY && !bus.WE && bus.AD == NMIV) m_nmi = 0;
    m_nmi_prev2 = m_nmi_prev1;
    m_nmi_prev1 = nmi_src;
    m_srcq = src;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("model_DO",  {8'h00, bus.DO}, {8'h00, m_do});
    check("model_hit", {15'h0, bus.hit}, {15'h0, m_hit});
    check("model_IRQ", {15'h0, irq}, {15'h0, m_irq});
    check("model_NMI", {15'h0, nmi}, {15'h0, m_nmi});
  endtask

  task automatic idle();
    bus.AD = 16'h0000; bus.WE = 1'b0; bus.RDY = 1'b1; bus.DI = 8'h00;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    bus.AD = BASE | {14'b0, off}; bus.WE = 1'b1; bus.DI = d;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [1:0] off, output logic [7:0] d, output logic h);
    bus.AD = BASE | {14'b0, off}; bus.WE = 1'b0;
    cyc();
    idle();
    d = bus.DO;
    h = bus.hit;
  endtask

  typedef struct {
    bit         we;
    logic [1:0] off;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] d;
  logic       h;
  int         r;

  initial begin
    idle();
    rst = 1'b1; src = 8'h00; nmi_src = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_DO",  {8'h00, bus.DO}, 16'h0000);
    check("rst_hit", {15'h0, bus.hit}, 16'h0000);
    check("rst_IRQ", {15'h0, irq}, 16'h0000);
    check("rst_NMI", {15'h0, nmi}, 16'h0000);
    repeat (3) cyc();
    check("nmi_high_thru_reset", {15'h0, nmi}, 16'h0000);
    nmi_src = 1'b0;
    cyc();

    tbl.push_back('{0, 2'd0, 8'h00, 8'h00});
    tbl.push_back('{0, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{0, 2'd2, 8'h00, 8'h00});
    tbl.push_back('{0, 2'd3, 8'h00, 8'h80});
    tbl.push_back('{1, 2'd1, 8'h05, 8'h00});
    tbl.push_back('{0, 2'd1, 8'h00, 8'h05});
    tbl.push_back('{1, 2'd2, 8'hA0, 8'h00});
    tbl.push_back('{0, 2'd2, 8'h00, 8'hA0});
    tbl.push_back('{1, 2'd3, 8'h55, 8'h00});
    tbl.push_back('{0, 2'd3, 8'h00, 8'h80});
    tbl.push_back('{0, 2'd0, 8'h00, 8'h00});
    tbl.push_back('{1, 2'd2, 8'h00, 8'h00});
    tbl.push_back('{1, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{0, 2'd1, 8'h00, 8'h00});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) wr(tbl[i].off, tbl[i].di);
      else begin
        rd(tbl[i].off, d, h);
        check($sformatf("tbl%0d_DO", i), {8'h00, d}, {8'h00, tbl[i].exp});
        check($sformatf("tbl%0d_hit", i), {15'h0, h}, 16'h0001);
      end
    end

    // Level source
    wr(2'd1, 8'h05);
    src = 8'h04;
    cyc(); check("lvl_irq_t1", {15'h0, irq}, 16'h0000);
    cyc(); check("lvl_irq_t2", {15'h0, irq}, 16'h0001);
    rd(2'd3, d, h); check("lvl_vec", {8'h00, d}, 16'h0002);
    rd(2'd3, d, h); check("lvl_vec_again", {8'h00, d}, 16'h0002);
    src = 8'h00;
    cyc(); check("lvl_drop_t1", {15'h0, irq}, 16'h0001);
    cyc(); check("lvl_drop_t2", {15'h0, irq}, 16'h0000);

    // Edge sources: two pulses acked by VECTOR reads
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'hFF);
    src = 8'h42; cyc(); src = 8'h00; cyc(); cyc();
    check("edge_irq", {15'h0, irq}, 16'h0001);
    rd(2'd3, d, h); check("edge_vec1", {8'h00, d}, 16'h0001);
    rd(2'd3, d, h); check("edge_vec6", {8'h00, d}, 16'h0006);
    rd(2'd3, d, h); check("edge_vec_none", {8'h00, d}, 16'h0080);
    check("edge_irq_fell", {15'h0, irq}, 16'h0000);

    // Same pulses, second one cleared by W1C
    src = 8'h42; cyc(); src = 8'h00; cyc(); cyc();
    rd(2'd3, d, h); check("w1c_vec1", {8'h00, d}, 16'h0001);
    wr(2'd0, 8'h40);
    rd(2'd3, d, h); check("w1c_vec_none", {8'h00, d}, 16'h0080);
    rd(2'd0, d, h); check("w1c_pend", {8'h00, d}, 16'h0000);

    // New edge on bit 3 during its own ack: set wins
    src = 8'h08; cyc(); src = 8'h00; cyc(); cyc();
    bus.AD = BASE | 16'h0003; bus.WE = 1'b0; src = 8'h08;
    cyc();
    idle(); src = 8'h00;
    check("conf_vec_first", {8'h00, bus.DO}, 16'h0003);
    rd(2'd3, d, h); check("conf_vec_kept", {8'h00, d}, 16'h0003);
    rd(2'd3, d, h); check("conf_vec_none", {8'h00, d}, 16'h0080);

    // NMI
    nmi_src = 1'b1;
    cyc(); check("nmi_t1", {15'h0, nmi}, 16'h0000);
    cyc(); check("nmi_t2", {15'h0, nmi}, 16'h0001);
    bus.AD = NMIV; bus.WE = 1'b1; cyc(); idle();
    check("nmi_write_no_clr", {15'h0, nmi}, 16'h0001);
    bus.AD = NMIV; bus.RDY = 1'b0; cyc(); idle();
    check("nmi_rdy0_no_clr", {15'h0, nmi}, 16'h0001);
    bus.AD = NMIV; cyc(); idle();
    check("nmi_ack", {15'h0, nmi}, 16'h0000);
    cyc(); cyc();
    check("nmi_level_no_retrig", {15'h0, nmi}, 16'h0000);
    nmi_src = 1'b0; cyc(); cyc();
    nmi_src = 1'b1; cyc();
    bus.AD = NMIV; cyc(); idle();
    check("nmi_edge_vs_ack", {15'h0, nmi}, 16'h0001);
    bus.AD = NMIV; cyc(); idle();
    check("nmi_ack2", {15'h0, nmi}, 16'h0000);
    nmi_src = 1'b0; cyc();

    // RDY=0 stalls
    wr(2'd1, 8'h01);
    wr(2'd2, 8'h01);
    src = 8'h01; cyc(); src = 8'h00; cyc(); cyc();
    bus.RDY = 1'b0; bus.AD = BASE | 16'h0001; bus.WE = 1'b1; bus.DI = 8'hFF;
    cyc(); idle();
    check("rdy0_wr_hit", {15'h0, bus.hit}, 16'h0000);
    bus.RDY = 1'b0; bus.AD = BASE | 16'h0003; bus.WE = 1'b0;
    cyc(); idle();
    check("rdy0_rd_hit", {15'h0, bus.hit}, 16'h0000);
    rd(2'd1, d, h); check("rdy0_mask_kept", {8'h00, d}, 16'h0001);
    rd(2'd3, d, h); check("rdy0_no_ack", {8'h00, d}, 16'h0000);
    rd(2'd3, d, h); check("rdy0_then_ack", {8'h00, d}, 16'h0080);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      bus.AD = BASE | 16'($urandom_range(0, 3));
      else if (r < 75) bus.AD = NMIV;
      else             bus.AD = 16'($urandom);
      bus.WE  = ($urandom_range(0, 99) < 35);
      bus.RDY = ($urandom_range(0, 99) < 85);
      bus.DI  = 8'($urandom);
      src     = src ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 99) < 6) nmi_src = ~nmi_src;
      rst = ($urandom_range(0, 999) < 5);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
